// File: rtl/register_file.sv
// register_file: eight 16-bit registers (R1-R4, S1-S4) with two read ports.
// Built from register_16bit cells; reset is layered on as a forced clear.
module register_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             E,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out
);

  // Enabled cell applies dec/inc/load/clear; disabled cell holds.
  always_ff @(posedge clock) begin
    if (E) begin
      unique case (FunSel)
        2'b00: Out <= Out - WIDTH'(1);
        2'b01: Out <= Out + WIDTH'(1);
        2'b10: Out <= In;
        2'b11: Out <= '0;
      endcase
    end
  end

endmodule

module register_file #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int NSCR  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [NREG-1:0]  RegSel,
  input  logic [NSCR-1:0]  ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam int N = NREG + NSCR;

  logic [WIDTH-1:0] q [N];
  logic [N-1:0]     en;
  logic [1:0]       fs;

  // Reset wins: every cell enabled with the clear opcode.
  always_comb begin
    en = {ScrSel, RegSel};
    fs = FunSel;
    if (reset) begin
      en = '1;
      fs = 2'b11;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_reg
    register_16bit #(.WIDTH(WIDTH)) u_reg (
      .clock  (clock),
      .E      (en[g]),
      .FunSel (fs),
      .In     (I),
      .Out    (q[g])
    );
  end

  // Read ports: indices 0-3 are R1-R4, 4-7 are S1-S4.
  always_comb begin
    OutA = q[OutASel];
    OutB = q[OutBSel];
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plus random stimulus against
// an array model of the eight registers.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] I;
  logic [1:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;

  int n_asrt = 0;
  int n_fail = 0;

  logic [15:0] m [8];

  register_file dut (
    .clock   (clock),
    .reset   (reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset  = 1'b0;
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
    FunSel = 2'b11;
    I      = 16'h0000;
  endtask

  // Drive a request shortly after a falling edge.
  task automatic op(input logic rst, input logic [1:0] f,
                    input logic [3:0] rs, input logic [3:0] ss,
                    input logic [15:0] d);
    @(negedge clock);
    reset  = rst;
    FunSel = f;
    RegSel = rs;
    ScrSel = ss;
    I      = d;
  endtask

  // Apply the pending request to the model, take the edge, go idle.
  task automatic tick();
    logic [7:0] e;
    e = {ScrSel, RegSel};
    for (int k = 0; k < 8; k++) begin
      if (reset) m[k] = 16'h0000;
      else if (e[k]) begin
        case (FunSel)
          2'b00: m[k] = 16'((32'(m[k]) + 32'hFFFF) % 32'h10000);
          2'b01: m[k] = 16'((32'(m[k]) + 1) % 32'h10000);
          2'b10: m[k] = I;
          default: m[k] = 16'h0000;
        endcase
      end
    end
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [2:0] b);
    OutASel = a;
    OutBSel = b;
    #1;
    chk({tag, "_A"}, OutA, m[a]);
    chk({tag, "_B"}, OutB, m[b]);
  endtask

  task automatic load(input logic [3:0] rs, input logic [3:0] ss,
                      input logic [15:0] d);
    op(1'b0, 2'b10, rs, ss, d);
    tick();
  endtask

  initial begin
    idle();
    OutASel = 3'd0;
    OutBSel = 3'd0;
    for (int k = 0; k < 8; k++) m[k] = 16'hxxxx;

    // 1: reset overrides a full load
    op(1'b1, 2'b10, 4'b1111, 4'b1111, 16'hAAAA);
    tick();
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k);
      OutBSel = 3'(7 - k);
      #1;
      chk("rst_A", OutA, 16'h0000);
      chk("rst_B", OutB, 16'h0000);
    end

    // 2: load and read-during-write
    op(1'b0, 2'b10, 4'b0001, 4'b0000, 16'h1234);
    OutASel = 3'd0;
    #1;
    chk("rdw_old", OutA, 16'h0000);
    tick();
    chk("rdw_new", OutA, 16'h1234);
    load(4'b0000, 4'b1000, 16'hBEEF);
    rd("ld_s4", 3'd0, 3'd7);
    chk("ld_s4c", OutB, 16'hBEEF);

    // 3: wrap-around
    load(4'b0010, 4'b0000, 16'hFFFF);
    op(1'b0, 2'b01, 4'b0010, 4'b0000, 16'h0);
    tick();
    OutASel = 3'd1;
    #1;
    chk("wrap_inc", OutA, 16'h0000);
    op(1'b0, 2'b00, 4'b0010, 4'b0000, 16'h0);
    tick();
    chk("wrap_dec", OutA, 16'hFFFF);
    load(4'b0000, 4'b0001, 16'h0000);
    op(1'b0, 2'b00, 4'b0000, 4'b0001, 16'h0);
    tick();
    OutBSel = 3'd4;
    #1;
    chk("wrap_s1", OutB, 16'hFFFF);

    // 4: multi-enable increment
    load(4'b0001, 4'b0000, 16'h0010);
    load(4'b0100, 4'b0000, 16'h0020);
    load(4'b0000, 4'b1000, 16'h0030);
    op(1'b0, 2'b01, 4'b0101, 4'b1000, 16'h0);
    tick();
    rd("multi_r1r3", 3'd0, 3'd2);
    chk("multi_r1", OutA, 16'h0011);
    chk("multi_r3", OutB, 16'h0021);
    rd("multi_s4r2", 3'd7, 3'd1);
    chk("multi_s4", OutA, 16'h0031);
    chk("multi_r2", OutB, 16'hFFFF);

    // 5: hold with no enables
    load(4'b1000, 4'b0000, 16'h5555);
    for (int k = 0; k < 3; k++) begin
      op(1'b0, 2'b11, 4'b0000, 4'b0000, 16'h0);
      tick();
    end
    rd("hold", 3'd3, 3'd3);
    chk("hold_c", OutA, 16'h5555);
    chk("hold_cb", OutB, 16'h5555);

    // 6: reset discards a concurrent increment
    load(4'b0001, 4'b0000, 16'h0007);
    op(1'b1, 2'b01, 4'b0001, 4'b0000, 16'h0);
    tick();
    OutASel = 3'd0;
    #1;
    chk("midrst", OutA, 16'h0000);
    op(1'b0, 2'b01, 4'b0001, 4'b0000, 16'h0);
    tick();
    chk("postrst", OutA, 16'h0001);

    // Random operations against the model
    for (int n = 0; n < 300; n++) begin
      op(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
         4'($urandom), 4'($urandom), 16'($urandom));
      if (n % 4 == 0) begin
        OutASel = 3'($urandom);
        #1;
        chk("rnd_rdw", OutA, m[OutASel]);
      end
      tick();
      rd("rnd", 3'($urandom), 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
